// File: rtl/add_roundkey_bank.sv
// AES AddRoundKey stage with a bank of NR+1 round keys and a single
// valid/ready output register. The key for each item is read from the bank
// as it stood before the clock edge. Items that name a slot past NR, or a
// slot that has never been loaded, come out with o_err set and zero data.
module add_roundkey_bank #(
   parameter int unsigned NR   = 10,
   parameter int unsigned KI_W = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_key_we,
   input  logic [KI_W-1:0] i_key_idx,
   input  logic [127:0]    i_key,
   input  logic            i_key_clr,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [127:0]    i_data,
   input  logic [KI_W-1:0] i_round,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [127:0]    o_data,
   output logic [KI_W-1:0] o_round,
   output logic            o_err
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned NSLOT = NR + 1;

   logic [BLK_W-1:0] keyBank [NSLOT];
   logic [NSLOT-1:0] keyLoaded;
   logic [BLK_W-1:0] selKey;
   logic             selLoaded;
   logic             inXfer;
   logic             outXfer;

   // The output register frees up in the same cycle it is drained.
   assign o_ready = !o_valid || i_ready;
   assign inXfer  = i_valid && o_ready;
   assign outXfer = o_valid && i_ready;

   // Select the round key for i_round; an index past NR matches no slot and reads as unloaded.
   always_comb begin
      selKey    = '0;
      selLoaded = 1'b0;
      for (int unsigned s = 0; s < NSLOT; s++) begin
         if (i_round == KI_W'(s)) begin
            selKey    = keyBank[s];
            selLoaded = keyLoaded[s];
         end
      end
   end

   // Key bank: clear wins over write; an out-of-range write index hits no slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned s = 0; s < NSLOT; s++) begin
            keyBank[s] <= '0;
         end
         keyLoaded <= '0;
      end else begin
         for (int unsigned s = 0; s < NSLOT; s++) begin
            if (i_key_clr) begin
               keyBank[s]   <= '0;
               keyLoaded[s] <= 1'b0;
            end else if (i_key_we && (i_key_idx == KI_W'(s))) begin
               keyBank[s]   <= i_key;
               keyLoaded[s] <= 1'b1;
            end
         end
      end
   end

   // Output stage: load on input transfer, otherwise empty on output transfer, else hold.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_round <= '0;
         o_err   <= 1'b0;
      end else if (inXfer) begin
         o_valid <= 1'b1;
         o_round <= i_round;
         if (selLoaded) begin
            o_data <= i_data ^ selKey;
            o_err  <= 1'b0;
         end else begin
            o_data <= '0;
            o_err  <= 1'b1;
         end
      end else if (outXfer) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_roundkey_bank.sv
// Bench for add_roundkey_bank (NR = 14): directed stimulus with a scoreboard
// fed from a reference key-bank model and drained on output transfers.
module tb_add_roundkey_bank;

   localparam int unsigned NR   = 14;
   localparam int unsigned KI_W = 4;

   logic            i_clk;
   logic            i_rst_n;
   logic            i_key_we;
   logic [KI_W-1:0] i_key_idx;
   logic [127:0]    i_key;
   logic            i_key_clr;
   logic            i_valid;
   logic            o_ready;
   logic [127:0]    i_data;
   logic [KI_W-1:0] i_round;
   logic            o_valid;
   logic            i_ready;
   logic [127:0]    o_data;
   logic [KI_W-1:0] o_round;
   logic            o_err;

   typedef struct packed {
      logic [127:0]    d;
      logic [KI_W-1:0] r;
      logic            e;
   } exp_t;

   exp_t         sb [$];
   logic [127:0] mKey    [0:15];
   logic         mLoaded [0:15];
   int           checks    = 0;
   int           errors    = 0;
   int           xferCount = 0;

   add_roundkey_bank #(.NR(NR), .KI_W(KI_W)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_we (i_key_we),
      .i_key_idx(i_key_idx),
      .i_key    (i_key),
      .i_key_clr(i_key_clr),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_data   (i_data),
      .i_round  (i_round),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_data   (o_data),
      .o_round  (o_round),
      .o_err    (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         sb.delete();
         for (int k = 0; k < 16; k++) begin
            mKey[k]    = '0;
            mLoaded[k] = 1'b0;
         end
         check("rst_o_valid", 128'(o_valid), 128'(0));
         check("rst_o_data", o_data, 128'(0));
      end else begin
         logic expReady;
         exp_t e;
         expReady = (sb.size() == 0) || i_ready;
         check("o_ready", 128'(o_ready), 128'(expReady));
         check("o_valid", 128'(o_valid), 128'(sb.size() != 0));
         if (sb.size() != 0) begin
            check("o_data", o_data, sb[0].d);
            check("o_round", 128'(o_round), 128'(sb[0].r));
            check("o_err", 128'(o_err), 128'(sb[0].e));
            if (i_ready) begin
               void'(sb.pop_front());
               xferCount++;
            end
         end
         if (i_valid && expReady) begin
            e.r = i_round;
            if ((int'(i_round) <= int'(NR)) && mLoaded[i_round]) begin
               e.d = i_data ^ mKey[i_round];
               e.e = 1'b0;
            end else begin
               e.d = '0;
               e.e = 1'b1;
            end
            sb.push_back(e);
         end
         if (i_key_clr) begin
            for (int k = 0; k < 16; k++) begin
               mKey[k]    = '0;
               mLoaded[k] = 1'b0;
            end
         end else if (i_key_we && (int'(i_key_idx) <= int'(NR))) begin
            mKey[i_key_idx]    = i_key;
            mLoaded[i_key_idx] = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic writeKey(input logic [KI_W-1:0] idx, input logic [127:0] key);
      i_key_we  = 1'b1;
      i_key_idx = idx;
      i_key     = key;
      tick();
      i_key_we  = 1'b0;
   endtask

   task automatic send(input logic [KI_W-1:0] rnd, input logic [127:0] data);
      i_valid = 1'b1;
      i_round = rnd;
      i_data  = data;
      tick();
      i_valid = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [127:0] keys [0:14];
      logic [127:0] dA, dB, newKey;
      int           base;

      i_rst_n = 1'b0; i_key_we = 1'b0; i_key_idx = '0; i_key = '0; i_key_clr = 1'b0;
      i_valid = 1'b0; i_data = '0; i_round = '0; i_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      check("reset_o_round", 128'(o_round), 128'(0));
      check("reset_o_err", 128'(o_err), 128'(0));
      i_rst_n = 1'b1;

      // First cycle after release: unloaded slot 0 must error
      send(4'd0, 128'h00112233445566778899aabbccddeeff);
      check("unloaded_err", 128'(o_err), 128'(1));
      check("unloaded_data", o_data, 128'(0));

      // FIPS-197 round 0 vector
      keys[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      writeKey(4'd0, keys[0]);
      send(4'd0, 128'h3243f6a8885a308d313198a2e0370734);
      check("fips_valid", 128'(o_valid), 128'(1));
      check("fips_data", o_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      check("fips_err", 128'(o_err), 128'(0));

      // Load all slots, stream 15 items back-to-back
      for (int k = 1; k <= 14; k++) begin
         keys[k] = rnd128() ^ 128'(k);
         writeKey(4'(k), keys[k]);
      end
      tick();
      base = xferCount;
      for (int k = 0; k <= 14; k++) begin
         i_valid = 1'b1;
         i_round = 4'(k);
         i_data  = rnd128();
         tick();
      end
      i_valid = 1'b0;
      tick();
      check("stream_count", 128'(xferCount - base), 128'(15));

      // Round past NR
      send(4'd15, rnd128());
      check("oor_err", 128'(o_err), 128'(1));
      check("oor_data", o_data, 128'(0));
      check("oor_round", 128'(o_round), 128'(15));

      // Backpressure for 5 cycles, then drain
      tick();
      base = xferCount;
      dA = rnd128();
      dB = rnd128();
      i_ready = 1'b0;
      i_valid = 1'b1; i_round = 4'd5; i_data = dA;
      tick();
      i_round = 4'd6; i_data = dB;
      repeat (5) begin
         check("bp_ready", 128'(o_ready), 128'(0));
         check("bp_hold", o_data, dA ^ keys[5]);
         tick();
      end
      i_ready = 1'b1;
      tick();
      i_valid = 1'b0;
      check("bp_second", o_data, dB ^ keys[6]);
      tick();
      tick();
      check("bp_count", 128'(xferCount - base), 128'(2));

      // Key write to the slot being read in the same cycle
      newKey = rnd128();
      dA = rnd128();
      i_valid = 1'b1; i_round = 4'd3; i_data = dA;
      i_key_we = 1'b1; i_key_idx = 4'd3; i_key = newKey;
      tick();
      i_valid = 1'b0; i_key_we = 1'b0;
      check("we_old_key", o_data, dA ^ keys[3]);
      keys[3] = newKey;
      dB = rnd128();
      send(4'd3, dB);
      check("we_new_key", o_data, dB ^ newKey);

      // Clear in the same cycle as a read
      dA = rnd128();
      i_valid = 1'b1; i_round = 4'd3; i_data = dA; i_key_clr = 1'b1;
      tick();
      i_valid = 1'b0; i_key_clr = 1'b0;
      check("clr_old_key", o_data, dA ^ newKey);
      send(4'd3, rnd128());
      check("clr_err", 128'(o_err), 128'(1));
      check("clr_data", o_data, 128'(0));

      // Out-of-range key write is ignored
      writeKey(4'd15, rnd128());
      send(4'd15, rnd128());
      check("oor_we_err", 128'(o_err), 128'(1));

      // Reset mid-stream with a held item
      writeKey(4'd0, keys[0]);
      i_ready = 1'b0;
      send(4'd0, rnd128());
      check("pre_rst_valid", 128'(o_valid), 128'(1));
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_rst_valid", 128'(o_valid), 128'(0));
      check("async_rst_data", o_data, 128'(0));
      tick();
      tick();
      i_ready = 1'b1;
      i_rst_n = 1'b1;
      send(4'd0, rnd128());
      check("post_rst_err", 128'(o_err), 128'(1));
      writeKey(4'd0, keys[0]);
      dA = rnd128();
      send(4'd0, dA);
      check("reload_data", o_data, dA ^ keys[0]);
      check("reload_err", 128'(o_err), 128'(0));
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
